// File: rtl/transceiver_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : transceiver_ctrl
// Description : Buffers UART bytes and runs each one through the Hamming
//               encode/decode pipe, BPSK modulation and UART retransmit.
// Revision    : 1.0 - initial release
// ============================================================================
module transceiver_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_LAT   = 2,
  parameter int MOD_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_rx_dv,
  input  logic [7:0]                    i_rx_byte,
  input  logic [7:0]                    i_dec_byte,
  input  logic                          i_tx_active,
  input  logic                          i_tx_done,
  output logic [7:0]                    o_enc_data,
  output logic                          o_mod_en,
  output logic                          o_tx_dv,
  output logic [7:0]                    o_tx_byte,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int CNT_MAX = (PIPE_LAT > MOD_CYCLES) ? PIPE_LAT : MOD_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] C_PIPE_LAST = CNTW'(PIPE_LAT - 1);
  localparam logic [CNTW-1:0] C_MOD_LAST  = CNTW'(MOD_CYCLES - 1);
  localparam logic [CW-1:0]   C_FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_PIPE = 3'd2,
    S_MODULATE  = 3'd3,
    S_TX_START  = 3'd4,
    S_TX_WAIT   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CNTW-1:0] r_cnt;
  logic [7:0]      r_enc_data;
  logic [7:0]      r_tx_byte;
  logic            r_mod_en;
  logic            r_tx_dv;
  logic            r_busy;
  logic            r_overflow;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_pipe_last;

  // A pop only ever happens in LOAD, which is entered solely with data buffered.
  assign w_full      = (r_count == C_FULL);
  assign w_pop       = (r_state == S_LOAD);
  assign w_push      = i_rx_dv && (!w_full || w_pop);
  assign w_pipe_last = (r_state == S_WAIT_PIPE) && (r_cnt == C_PIPE_LAST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (i_rx_dv && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (r_count != '0) w_next = S_LOAD;
      S_LOAD:      w_next = S_WAIT_PIPE;
      S_WAIT_PIPE: if (r_cnt == C_PIPE_LAST) w_next = S_MODULATE;
      S_MODULATE:  if (r_cnt == C_MOD_LAST) w_next = S_TX_START;
      S_TX_START:  if (!i_tx_active) w_next = S_TX_WAIT;
      S_TX_WAIT:   if (i_tx_done) w_next = (r_count != '0) ? S_LOAD : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Status outputs are flops loaded from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_enc_data <= '0;
      r_tx_byte  <= '0;
      r_mod_en   <= 1'b0;
      r_tx_dv    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mod_en <= (w_next == S_MODULATE);
      r_busy   <= (w_next != S_IDLE);
      r_tx_dv  <= (r_state == S_TX_START) && !i_tx_active;
      if (r_state == S_LOAD) begin
        r_enc_data <= r_mem[r_rd_ptr];
        r_cnt      <= '0;
      end else if (w_pipe_last) begin
        r_tx_byte <= i_dec_byte;
        r_cnt     <= '0;
      end else if ((r_state == S_WAIT_PIPE) || (r_state == S_MODULATE)) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  assign o_enc_data   = r_enc_data;
  assign o_mod_en     = r_mod_en;
  assign o_tx_dv      = r_tx_dv;
  assign o_tx_byte    = r_tx_byte;
  assign o_busy       = r_busy;
  assign o_overflow   = r_overflow;
  assign o_fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_transceiver_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : tb_transceiver_ctrl
// Description : Directed, table-driven bench for transceiver_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transceiver_ctrl;

  localparam int FD = 4;
  localparam int PL = 2;
  localparam int MC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] dec_byte;
  logic       tx_active;
  logic       tx_done;
  logic       force_active = 1'b0;
  logic [7:0] enc_data;
  logic       mod_en;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  transceiver_ctrl #(.FIFO_DEPTH(FD), .PIPE_LAT(PL), .MOD_CYCLES(MC)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_dv      (rx_dv),
    .i_rx_byte    (rx_byte),
    .i_dec_byte   (dec_byte),
    .i_tx_active  (tx_active),
    .i_tx_done    (tx_done),
    .o_enc_data   (enc_data),
    .o_mod_en     (mod_en),
    .o_tx_dv      (tx_dv),
    .o_tx_byte    (tx_byte),
    .o_busy       (busy),
    .o_overflow   (overflow),
    .o_fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Decoder model: registered, so the byte is ready one edge after enc_data
  // updates and is captured on the second (PIPE_LAT-th) edge.
  logic [7:0] r_dec = 8'h00;
  always @(posedge clk) r_dec <= enc_data;
  assign dec_byte = r_dec;

  // UART transmitter model: busy 3 cycles after tx_dv, then a done strobe.
  int   u_cnt = 0;
  logic u_done = 1'b0;
  always @(posedge clk) begin
    if (tx_dv) begin
      u_cnt  <= 3;
      u_done <= 1'b0;
    end else if (u_cnt == 1) begin
      u_cnt  <= 0;
      u_done <= 1'b1;
    end else begin
      if (u_cnt != 0) u_cnt <= u_cnt - 1;
      u_done <= 1'b0;
    end
  end
  assign tx_active = force_active | (u_cnt != 0);
  assign tx_done   = u_done;

  logic [7:0] q[$];
  int         dv_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && tx_dv) begin
      q.push_back(tx_byte);
      dv_cnt++;
    end
  end

  typedef struct {
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [2:0] cnt;
    logic       busy;
    logic       mod;
    logic       dv;
    logic [7:0] enc;
  } vec_t;
  vec_t vt[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic wait_mod(input logic v, input int lim);
    int n = 0;
    while (mod_en !== v && n < lim) begin
      tick();
      n++;
    end
    chk("wait_mod_en", mod_en, v);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int q_base;
    int dv_base;
    int lows;
    int n;

    // Single 0xA5 transaction, one row per clock edge (edge 0 samples rx_dv).
    for (int i = 0; i < 19; i++) vt[i] = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[0] = '{1'b1, 8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    for (int i = 4; i < 12; i++) vt[i].mod = 1'b1;
    vt[13].dv   = 1'b1;
    vt[18].busy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mod_en", mod_en, 0);
    chk("rst_tx_dv", tx_dv, 0);
    chk("rst_enc", enc_data, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    dv_base = dv_cnt;
    for (int i = 0; i < 19; i++) begin
      rx_dv   = vt[i].rx_dv;
      rx_byte = vt[i].rx_byte;
      tick();
      chk($sformatf("v%0d_count", i), fifo_count, vt[i].cnt);
      chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("v%0d_mod_en", i), mod_en, vt[i].mod);
      chk($sformatf("v%0d_tx_dv", i), tx_dv, vt[i].dv);
      chk($sformatf("v%0d_enc", i), enc_data, vt[i].enc);
    end
    rx_dv = 1'b0;
    chk("single_tx_byte", tx_byte, 8'hA5);
    chk("single_dv_pulses", dv_cnt - dv_base, 1);

    // Five back-to-back strobes while busy: fourth fills, fifth is dropped.
    q_base  = q.size();
    dv_base = dv_cnt;
    send(8'h10);
    tick();
    tick();
    for (int k = 1; k <= 5; k++) send(8'h10 + 8'(k));
    chk("burst_count_full", fifo_count, 4);
    chk("burst_overflow", overflow, 1);
    lows = 0;
    n = 0;
    while (dv_cnt < dv_base + 5 && n < 500) begin
      tick();
      n++;
      if (busy !== 1'b1) lows++;
    end
    chk("burst_all_sent", dv_cnt - dv_base, 5);
    chk("burst_no_idle_gap", lows, 0);
    wait_idle(50);
    for (int k = 0; k < 5; k++)
      if (q_base + k < q.size()) chk($sformatf("burst_order%0d", k), q[q_base + k], 8'h10 + 8'(k));
      else chk($sformatf("burst_order%0d", k), 32'hFFFF, 8'h10 + 8'(k));
    chk("burst_overflow_sticky", overflow, 1);

    rst_n = 1'b0;
    #2;
    chk("async_clear_overflow", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Push coincident with the LOAD pop while full.
    q_base  = q.size();
    dv_base = dv_cnt;
    send(8'h20);
    tick();
    tick();
    for (int k = 1; k <= 4; k++) send(8'h20 + 8'(k));
    chk("full_count", fifo_count, 4);
    n = 0;
    while (tx_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("wait_tx_done", tx_done, 1);
    tick();
    rx_dv   = 1'b1;
    rx_byte = 8'h25;
    tick();
    rx_dv = 1'b0;
    chk("pop_push_count", fifo_count, 4);
    chk("pop_push_overflow", overflow, 0);
    n = 0;
    while (dv_cnt < dv_base + 6 && n < 600) begin
      tick();
      n++;
    end
    wait_idle(50);
    for (int k = 0; k < 6; k++)
      if (q_base + k < q.size()) chk($sformatf("pp_order%0d", k), q[q_base + k], 8'h20 + 8'(k));
      else chk($sformatf("pp_order%0d", k), 32'hFFFF, 8'h20 + 8'(k));

    // Transmitter held busy on entry to TX_START.
    dv_base = dv_cnt;
    send(8'h5A);
    force_active = 1'b1;
    wait_mod(1'b1, 20);
    wait_mod(1'b0, 20);
    n = 0;
    repeat (20) begin
      tick();
      if (tx_dv) n++;
    end
    chk("hold_no_tx_dv", n, 0);
    force_active = 1'b0;
    tick();
    chk("release_tx_dv_hi", tx_dv, 1);
    tick();
    chk("release_tx_dv_lo", tx_dv, 0);
    wait_idle(50);
    chk("hold_dv_pulses", dv_cnt - dv_base, 1);
    chk("hold_tx_byte", tx_byte, 8'h5A);

    // Reset during MODULATE with two bytes queued.
    send(8'h30);
    tick();
    tick();
    send(8'h31);
    send(8'h32);
    chk("mid_count", fifo_count, 2);
    wait_mod(1'b1, 20);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mod_en", mod_en, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_enc", enc_data, 0);
    chk("mid_rst_tx_byte", tx_byte, 0);
    chk("mid_rst_tx_dv", tx_dv, 0);
    tick();
    rst_n = 1'b1;
    dv_base = dv_cnt;
    repeat (60) tick();
    chk("post_rst_no_tx_dv", dv_cnt - dv_base, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
